// File: rtl/cv1k_pkg.sv
// cv1k_pkg: shared constants and types for the CV1K CS4 serial bridge.
//   - region codes decoded from A23-A22
//   - register select codes (A1-A0) inside the bridge region
//   - serial engine state encoding
//   - key value that releases the peripheral (audio) reset
package cv1k_pkg;

    localparam logic [1:0] REG_U2     = 2'd0;
    localparam logic [1:0] REG_AUDIO  = 2'd1;
    localparam logic [1:0] REG_BRIDGE = 2'd3;

    localparam logic [1:0] AL_DATA  = 2'b00;  // tx push / rx pop
    localparam logic [1:0] AL_CTRL  = 2'b01;  // legacy bit-bang / status
    localparam logic [1:0] AL_SETUP = 2'b10;  // device_ready key
    localparam logic [1:0] AL_START = 2'b11;  // frame start, nibble count

    localparam logic [3:0] SETUP_KEY = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_HOLD  = 3'd4
    } eng_st_t;

endpackage

// File: rtl/cv1k_serial_bridge_if.sv
// cv1k_serial_bridge_if: SH-3 CS4 bus as seen by the bridge.
//   cs4, sh3_rd, sh3_we  active-low strobes from the CPU
//   addr_high            A23-A22 region code
//   addr_low             A1-A0 register select (bridge region)
//   data_in / data_out   nibble data bus, split by direction
//   data_oe              bridge drives the pad during region-3 reads
//   sh3_wait             active-low wait back to the CPU
// master = CPU side, slave = bridge side.
interface cv1k_serial_bridge_if #(
    parameter int DATA_W = 4
);
    logic              cs4;
    logic              sh3_rd;
    logic              sh3_we;
    logic [1:0]        addr_high;
    logic [1:0]        addr_low;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              sh3_wait;

    modport master (
        output cs4, sh3_rd, sh3_we, addr_high, addr_low, data_in,
        input  data_out, data_oe, sh3_wait
    );

    modport slave (
        input  cs4, sh3_rd, sh3_we, addr_high, addr_low, data_in,
        output data_out, data_oe, sh3_wait
    );
endinterface

// File: rtl/cv1k_ser_shifter.sv
// cv1k_ser_shifter: serial frame engine for the EEPROM/RTC device.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        one-cycle start, honoured only when idle
//   i_nib          frame length in nibbles (already range checked)
//   i_tx           transmit buffer; the low L bits form the frame
//   i_rx_pop       shift the received window left by one nibble
//   o_rx_nib       top nibble of the received L-bit window
//   o_busy         engine not idle
//   o_ser_ce/clk/di engine drive of the serial pins (0 when idle)
//   i_ser_do       serial data from the device
// Frame: SETUP, then L x (LO, HI), then HOLD, each CLK_DIV clocks.
// ser_do is sampled on the LO->HI edge, MSB-first.
module cv1k_ser_shifter
    import cv1k_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int SHIFT_W = 16,
    parameter int CLK_DIV = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [DATA_W-1:0]  i_nib,
    input  logic [SHIFT_W-1:0] i_tx,
    input  logic               i_rx_pop,
    output logic [DATA_W-1:0]  o_rx_nib,
    output logic               o_busy,
    output logic               o_ser_ce,
    output logic               o_ser_clk,
    output logic               o_ser_di,
    input  logic               i_ser_do
);

    localparam int NIB_MAX = SHIFT_W / DATA_W;
    localparam int NIB_W   = $clog2(NIB_MAX + 1);
    localparam int LEN_W   = $clog2(SHIFT_W + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    eng_st_t              r_st, w_nxt;
    logic [DIV_W-1:0]     r_div;
    logic [LEN_W-1:0]     r_left;   // bits still to send, including current
    logic [SHIFT_W-1:0]   r_sh;     // tx frame, current bit at MSB
    logic [SHIFT_W-1:0]   r_rx;
    logic [NIB_W-1:0]     r_rdn;    // nibbles in the received window
    logic [LEN_W-1:0]     w_len;
    logic [SHIFT_W-1:0]   w_rx_al;
    logic                 w_tick;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_len  = LEN_W'(int'(i_nib) * DATA_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_st <= ST_IDLE;
        else       r_st <= w_nxt;
    end

    always_comb begin
        w_nxt = r_st;
        case (r_st)
            ST_IDLE:  if (i_start) w_nxt = ST_SETUP;
            ST_SETUP: if (w_tick)  w_nxt = ST_LO;
            ST_LO:    if (w_tick)  w_nxt = ST_HI;
            ST_HI:    if (w_tick)  w_nxt = (r_left == LEN_W'(1)) ? ST_HOLD : ST_LO;
            ST_HOLD:  if (w_tick)  w_nxt = ST_IDLE;
            default:               w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_left <= '0;
            r_sh   <= '0;
            r_rx   <= '0;
            r_rdn  <= NIB_W'(NIB_MAX);
        end else begin
            r_div <= (r_st == ST_IDLE || w_tick) ? '0 : r_div + DIV_W'(1);
            if (r_st == ST_IDLE) begin
                if (i_start) begin
                    // left-align the L-bit frame so the first bit sits at the MSB
                    r_sh   <= i_tx << (SHIFT_W - int'(w_len));
                    r_rx   <= '0;
                    r_left <= w_len;
                    r_rdn  <= NIB_W'(i_nib);
                end else if (i_rx_pop) begin
                    r_rx <= r_rx << DATA_W;
                end
            end
            if (r_st == ST_LO && w_tick)
                r_rx <= {r_rx[SHIFT_W-2:0], i_ser_do};
            if (r_st == ST_HI && w_tick) begin
                r_sh   <= r_sh << 1;
                r_left <= r_left - LEN_W'(1);
            end
        end
    end

    // Read-out is taken from the top of the L-bit window, so a short
    // frame still returns its first received nibble first.
    assign w_rx_al  = r_rx >> ((int'(r_rdn) - 1) * DATA_W);
    assign o_rx_nib = w_rx_al[DATA_W-1:0];

    assign o_busy    = (r_st != ST_IDLE);
    assign o_ser_ce  = o_busy;
    assign o_ser_clk = (r_st == ST_HI);
    assign o_ser_di  = (r_st == ST_LO || r_st == ST_HI) ? r_sh[SHIFT_W-1] : 1'b0;

endmodule

// File: rtl/cv1k_serial_bridge.sv
// cv1k_serial_bridge: CS4 bus bridge between the SH-3 and board peripherals.
//   i_clk, i_rst     clock, synchronous active-high reset
//   bus              CPU bus (cv1k_serial_bridge_if.slave)
//   o_dev_cs_n       active-low chip select per region 0..NUM_CS-1
//   o_dev_re_n/we_n  region-0 read/write strobes
//   o_ser_ce/clk/di  serial device pins (engine when busy, legacy reg when idle)
//   i_ser_do         serial data from the device
//   o_device_ready   sticky, set by the setup key; releases audio reset
// Optional feature macro: CV1K_WAIT_EN -- stretches region-3 accesses with
// sh3_wait and holds data/start accesses until the engine is idle instead
// of dropping them.
module cv1k_serial_bridge
    import cv1k_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int NUM_CS   = 3,
    parameter int SHIFT_W  = 16,
    parameter int CLK_DIV  = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    cv1k_serial_bridge_if.slave  bus,
    output logic [NUM_CS-1:0]    o_dev_cs_n,
    output logic                 o_dev_re_n,
    output logic                 o_dev_we_n,
    output logic                 o_ser_ce,
    output logic                 o_ser_clk,
    output logic                 o_ser_di,
    input  logic                 i_ser_do,
    output logic                 o_device_ready
);

    localparam int NIB_MAX = SHIFT_W / DATA_W;

    logic               r_act_q;
    logic [SHIFT_W-1:0] r_tx;
    logic [2:0]         r_leg;     // {ce, clk, di} legacy bit-bang
    logic               r_ready;
    logic [DATA_W-1:0]  r_dout;

    logic               w_act, w_acc, w_do, w_wr;
    logic               w_busy, w_start, w_pop, w_len_ok;
    logic [DATA_W-1:0]  w_rx_nib, w_rd_data;
    logic               w_eng_ce, w_eng_clk, w_eng_di;

    // ---------------- decode ----------------
    for (genvar r = 0; r < NUM_CS; r++) begin : g_cs
        assign o_dev_cs_n[r] = bus.cs4 | (bus.addr_high != 2'(r));
    end
    assign o_dev_re_n = bus.sh3_rd | bus.cs4 | (bus.addr_high != REG_U2);
    assign o_dev_we_n = bus.sh3_we | bus.cs4 | (bus.addr_high != REG_U2);
    assign bus.data_oe = !bus.cs4 && !bus.sh3_rd && (bus.addr_high == REG_BRIDGE);

    // ---------------- access strobe ----------------
    assign w_act = !bus.cs4 && (!bus.sh3_rd || !bus.sh3_we) && (bus.addr_high == REG_BRIDGE);
    assign w_acc = w_act && !r_act_q;
    assign w_wr  = !bus.sh3_we;

`ifdef CV1K_WAIT_EN
    localparam int WC_W = $clog2(WAIT_CYC + 2);
    logic            r_pend;
    logic [WC_W-1:0] r_wcnt;
    logic            w_blk;

    // data/start accesses during a frame are parked and replayed at idle
    assign w_blk = w_busy && (bus.addr_low == AL_DATA || bus.addr_low == AL_START);
    assign w_do  = (w_acc && !w_blk) || (r_pend && !w_busy && w_act);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_wcnt <= '0;
        end else begin
            if (w_acc && w_blk)         r_pend <= 1'b1;
            else if (!w_busy || !w_act) r_pend <= 1'b0;
            if (w_do)                   r_wcnt <= WC_W'(WAIT_CYC);
            else if (r_wcnt != '0)      r_wcnt <= r_wcnt - WC_W'(1);
        end
    end

    assign bus.sh3_wait = !(r_pend || (r_wcnt != '0));
`else
    assign w_do         = w_acc;
    assign bus.sh3_wait = 1'b1;
`endif

    // ---------------- register map ----------------
    assign w_len_ok = (bus.data_in != '0) && (int'(bus.data_in) <= NIB_MAX);
    assign w_start  = w_do && w_wr && (bus.addr_low == AL_START) && !w_busy && w_len_ok;
    assign w_pop    = w_do && !w_wr && (bus.addr_low == AL_DATA) && !w_busy;

    always_comb begin
        w_rd_data = '0;
        case (bus.addr_low)
            AL_DATA: w_rd_data = w_busy ? '0 : w_rx_nib;
            AL_CTRL: w_rd_data = DATA_W'({w_busy, r_ready, 1'b0, i_ser_do});
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act_q <= 1'b0;
            r_tx    <= '0;
            r_leg   <= '0;
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_act_q <= w_act;
            if (w_do && w_wr) begin
                case (bus.addr_low)
                    AL_DATA:  if (!w_busy) r_tx <= {r_tx[SHIFT_W-DATA_W-1:0], bus.data_in};
                    AL_CTRL:  if (!w_busy) r_leg <= bus.data_in[2:0];
                    AL_SETUP: if (bus.data_in == DATA_W'(SETUP_KEY)) r_ready <= 1'b1;
                    default: ;
                endcase
            end
            // read data is latched on the strobe so the pop cannot disturb it
            if (w_do && !w_wr) r_dout <= w_rd_data;
        end
    end

    assign bus.data_out   = r_dout;
    assign o_device_ready = r_ready;

    // ---------------- serial engine ----------------
    cv1k_ser_shifter #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_nib     (bus.data_in),
        .i_tx      (r_tx),
        .i_rx_pop  (w_pop),
        .o_rx_nib  (w_rx_nib),
        .o_busy    (w_busy),
        .o_ser_ce  (w_eng_ce),
        .o_ser_clk (w_eng_clk),
        .o_ser_di  (w_eng_di),
        .i_ser_do  (i_ser_do)
    );

    // engine owns the pins while busy; legacy register otherwise
    assign o_ser_ce  = w_busy ? w_eng_ce  : r_leg[2];
    assign o_ser_clk = w_busy ? w_eng_clk : r_leg[1];
    assign o_ser_di  = w_busy ? w_eng_di  : r_leg[0];

endmodule

// File: tb/tb_cv1k_serial_bridge.sv
module tb_cv1k_serial_bridge;

    logic       clk;
    logic       rst;
    logic [2:0] dev_cs_n;
    logic       dev_re_n, dev_we_n, ser_ce, ser_clk, ser_di, ser_do, device_ready;
    int         checks = 0;
    int         fails  = 0;
    logic [3:0] exp_q[$];     // expected read nibbles
    logic       exp_bits[$];  // expected ser_di bits at each ser_clk rise
    logic       saw_wait;

    cv1k_serial_bridge_if #(.DATA_W(4)) bus ();

    cv1k_serial_bridge dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .bus            (bus),
        .o_dev_cs_n     (dev_cs_n),
        .o_dev_re_n     (dev_re_n),
        .o_dev_we_n     (dev_we_n),
        .o_ser_ce       (ser_ce),
        .o_ser_clk      (ser_clk),
        .o_ser_di       (ser_di),
        .i_ser_do       (ser_do),
        .o_device_ready (device_ready)
    );

    assign ser_do = ser_di;  // loopback

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.sh3_wait === 1'b0) saw_wait = 1'b1;

    task automatic bus_idle();
        bus.cs4 = 1'b1; bus.sh3_rd = 1'b1; bus.sh3_we = 1'b1;
        bus.addr_high = 2'd0; bus.addr_low = 2'd0; bus.data_in = 4'd0;
    endtask

    // one region-3 access; holds the bus through any wait
    task automatic cpu_acc(input logic wr, input logic [1:0] al, input logic [3:0] d,
                           output logic [3:0] q);
        int n;
        @(negedge clk);
        bus.cs4 = 1'b0; bus.addr_high = 2'd3; bus.addr_low = al; bus.data_in = d;
        bus.sh3_we = !wr; bus.sh3_rd = wr;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (bus.sh3_wait === 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            fails++;
            $display("FAIL acc_wait_timeout got=%0d cycles need<2000", n);
        end
        q = bus.data_out;
        bus_idle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ser_ce !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            fails++;
            $display("FAIL idle_timeout got ser_ce=%b need 0", ser_ce);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_idle();
        repeat (3) @(negedge clk);
        checks++; if ({ser_ce, ser_clk, ser_di} !== 3'b000) begin fails++; $display("FAIL rst_ser got=%b need=000", {ser_ce, ser_clk, ser_di}); end
        checks++; if (device_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b need=0", device_ready); end
        checks++; if (dev_cs_n !== 3'b111) begin fails++; $display("FAIL rst_cs got=%b need=111", dev_cs_n); end
        checks++; if ({dev_re_n, dev_we_n} !== 2'b11) begin fails++; $display("FAIL rst_strb got=%b need=11", {dev_re_n, dev_we_n}); end
        checks++; if (bus.sh3_wait !== 1'b1) begin fails++; $display("FAIL rst_wait got=%b need=1", bus.sh3_wait); end
        checks++; if (bus.data_oe !== 1'b0) begin fails++; $display("FAIL rst_oe got=%b need=0", bus.data_oe); end
        checks++; if (bus.data_out !== 4'h0) begin fails++; $display("FAIL rst_dout got=%h need=0", bus.data_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decode();
        @(negedge clk); bus.cs4 = 1'b0; bus.addr_high = 2'd1; #1;
        checks++; if (dev_cs_n !== 3'b101) begin fails++; $display("FAIL dec_r1 got=%b need=101", dev_cs_n); end
        bus.addr_high = 2'd2; #1;
        checks++; if (dev_cs_n !== 3'b011) begin fails++; $display("FAIL dec_r2 got=%b need=011", dev_cs_n); end
        bus.addr_high = 2'd0; bus.sh3_rd = 1'b0; #1;
        checks++; if ({dev_cs_n, dev_re_n, dev_we_n} !== 5'b110_0_1) begin fails++; $display("FAIL dec_rd0 got=%b need=11001", {dev_cs_n, dev_re_n, dev_we_n}); end
        bus.sh3_rd = 1'b1; bus.sh3_we = 1'b0; #1;
        checks++; if ({dev_re_n, dev_we_n} !== 2'b10) begin fails++; $display("FAIL dec_wr0 got=%b need=10", {dev_re_n, dev_we_n}); end
        bus.sh3_we = 1'b1; bus.sh3_rd = 1'b0; bus.addr_high = 2'd3; bus.addr_low = 2'b10; #1;
        checks++; if ({dev_cs_n, dev_re_n, bus.data_oe} !== 5'b111_1_1) begin fails++; $display("FAIL dec_r3 got=%b need=11111", {dev_cs_n, dev_re_n, bus.data_oe}); end
        bus.cs4 = 1'b1; #1;
        checks++; if ({dev_cs_n, bus.data_oe} !== 4'b111_0) begin fails++; $display("FAIL dec_nocs got=%b need=1110", {dev_cs_n, bus.data_oe}); end
        wait_idle();
        bus_idle();
    endtask

    task automatic test_setup();
        logic [3:0] q;
        cpu_acc(1'b1, 2'b10, 4'b1111, q);
        checks++; if (device_ready !== 1'b0) begin fails++; $display("FAIL setup_badkey got=%b need=0", device_ready); end
        cpu_acc(1'b0, 2'b01, 4'h0, q);
        checks++; if (q !== 4'b0000) begin fails++; $display("FAIL status_pre got=%b need=0000", q); end
        cpu_acc(1'b1, 2'b10, 4'b1110, q);
        checks++; if (device_ready !== 1'b1) begin fails++; $display("FAIL setup_key got=%b need=1", device_ready); end
        cpu_acc(1'b0, 2'b01, 4'h0, q);
        checks++; if (q !== 4'b0100) begin fails++; $display("FAIL status_post got=%b need=0100", q); end
    endtask

    task automatic test_legacy();
        logic [3:0] q;
        cpu_acc(1'b1, 2'b01, 4'b0101, q);
        checks++; if ({ser_ce, ser_clk, ser_di} !== 3'b101) begin fails++; $display("FAIL legacy_set got=%b need=101", {ser_ce, ser_clk, ser_di}); end
        cpu_acc(1'b1, 2'b01, 4'b0010, q);
        checks++; if ({ser_ce, ser_clk, ser_di} !== 3'b010) begin fails++; $display("FAIL legacy_set2 got=%b need=010", {ser_ce, ser_clk, ser_di}); end
        cpu_acc(1'b1, 2'b01, 4'b0000, q);
    endtask

    task automatic test_shift();
        logic [3:0] q, e;
        int ce_cyc, pulses;
        cpu_acc(1'b1, 2'b00, 4'hA, q);
        cpu_acc(1'b1, 2'b00, 4'h5, q);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(((8'hA5 >> i) & 8'h1) != 0);
        ce_cyc = 0; pulses = 0;
        fork
            cpu_acc(1'b1, 2'b11, 4'd2, q);
            begin
                int n;
                logic prev;
                n = 0; prev = 1'b0;
                while (ser_ce !== 1'b1 && n < 100) begin @(negedge clk); n++; end
                while (ser_ce === 1'b1 && ce_cyc < 500) begin
                    if (ser_clk === 1'b1 && !prev) begin
                        pulses++;
                        e = {3'b0, (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'bx};
                        checks++; if (ser_di !== e[0]) begin fails++; $display("FAIL shift_bit%0d got=%b need=%b", pulses, ser_di, e[0]); end
                    end
                    prev = ser_clk; ce_cyc++;
                    @(negedge clk);
                end
            end
        join
        checks++; if (ce_cyc != 72) begin fails++; $display("FAIL shift_busy got=%0d need=72", ce_cyc); end
        checks++; if (pulses != 8) begin fails++; $display("FAIL shift_pulses got=%0d need=8", pulses); end
        exp_q.push_back(4'hA); exp_q.push_back(4'h5);
        repeat (2) begin
            cpu_acc(1'b0, 2'b00, 4'h0, q);
            e = exp_q.pop_front();
            checks++; if (q !== e) begin fails++; $display("FAIL shift_rx got=%h need=%h", q, e); end
        end
    endtask

    // 1-nibble frame (tx low nibble 5); read 00 while busy
    task automatic test_busy_read();
        logic [3:0] q, e;
        cpu_acc(1'b1, 2'b11, 4'd1, q);
        checks++; if (ser_ce !== 1'b1) begin fails++; $display("FAIL busyrd_started got=%b need=1", ser_ce); end
        saw_wait = 1'b0;
`ifdef CV1K_WAIT_EN
        exp_q.push_back(4'h5);
`else
        exp_q.push_back(4'h0);
`endif
        cpu_acc(1'b0, 2'b00, 4'h0, q);
        e = exp_q.pop_front();
        checks++; if (q !== e) begin fails++; $display("FAIL busyrd_data got=%h need=%h", q, e); end
`ifdef CV1K_WAIT_EN
        checks++; if (saw_wait !== 1'b1 || ser_ce !== 1'b0) begin fails++; $display("FAIL busyrd_wait got=%b/%b need=1/0", saw_wait, ser_ce); end
        exp_q.push_back(4'h0);
`else
        checks++; if (saw_wait !== 1'b0) begin fails++; $display("FAIL busyrd_wait got=%b need=0", saw_wait); end
        exp_q.push_back(4'h5);
`endif
        wait_idle();
        cpu_acc(1'b0, 2'b00, 4'h0, q);
        e = exp_q.pop_front();
        checks++; if (q !== e) begin fails++; $display("FAIL busyrd_after got=%h need=%h", q, e); end
    endtask

    task automatic test_guards();
        logic [3:0] q;
        logic [3:0] bad[2];
        bad[0] = 4'd0; bad[1] = 4'd5;
        for (int i = 0; i < 2; i++) begin
            logic seen;
            seen = 1'b0;
            cpu_acc(1'b1, 2'b11, bad[i], q);
            repeat (20) begin @(negedge clk); if (ser_ce !== 1'b0) seen = 1'b1; end
            checks++; if (seen !== 1'b0) begin fails++; $display("FAIL guard_n%0d got=1 need=0", bad[i]); end
        end
        cpu_acc(1'b1, 2'b11, 4'd1, q);
        cpu_acc(1'b1, 2'b01, 4'b0111, q);
        wait_idle();
        @(negedge clk);
        checks++; if ({ser_ce, ser_clk, ser_di} !== 3'b000) begin fails++; $display("FAIL guard_legacy got=%b need=000", {ser_ce, ser_clk, ser_di}); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] q;
        int n;
        cpu_acc(1'b1, 2'b11, 4'd4, q);
        n = 0;
        while (ser_clk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (ser_clk !== 1'b1 || device_ready !== 1'b1) begin fails++; $display("FAIL rmid_pre got=%b%b need=11", ser_clk, device_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ser_ce, ser_clk, ser_di} !== 3'b000) begin fails++; $display("FAIL rmid_ser got=%b need=000", {ser_ce, ser_clk, ser_di}); end
        checks++; if (device_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready got=%b need=0", device_ready); end
        rst = 1'b0;
        cpu_acc(1'b0, 2'b01, 4'h0, q);
        checks++; if (q !== 4'b0000) begin fails++; $display("FAIL rmid_status got=%b need=0000", q); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_setup();
        test_legacy();
        test_shift();
        test_busy_read();
        test_guards();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
